// File: rtl/am25xx_pkg.sv
// Shared definitions for the am25xx successive-approximation register family.
package am25xx_pkg;

  // Default register length; the 12-bit variant overrides WIDTH at instantiation.
  localparam int unsigned AM25XX_WIDTH = 8;

  // Conversion sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } sar_state_t;

endpackage

// File: rtl/am2502.sv
// am2502: successive-approximation register. A start loads 1000..0; each
// enabled edge in CONV keeps or clears the bit under trial according to d and
// sets the next lower bit for trial. All outputs come straight from registers.
module am2502
  import am25xx_pkg::*;
#(
  parameter int unsigned WIDTH = AM25XX_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_n,
  input  logic             e_n,
  input  logic             d,
  output logic [WIDTH-1:0] q,
  output logic             qs,
  output logic             cc_n
);

  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

  sar_state_t       state;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] q_trial;

  // Next value of q during a trial edge. Bits below m-1 are already zero, so
  // OR-ing in (m >> 1) sets the next trial bit without disturbing anything
  // else; on the final bit (m[0]) the shift contributes nothing.
  always_comb begin
    q_trial = (q & ~m) | (d ? m : '0) | (m >> 1);
  end

  // Sequencer, trial marker and data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      qs    <= 1'b0;
      cc_n  <= 1'b1;
      m     <= '0;
      state <= IDLE;
    end else if (!e_n) begin
      if (!start_n) begin
        q     <= MSB_ONLY;
        m     <= MSB_ONLY;
        cc_n  <= 1'b1;
        state <= CONV;
      end else begin
        case (state)
          CONV: begin
            q  <= q_trial;
            qs <= d;
            if (m[0]) begin
              cc_n  <= 1'b0;
              state <= DONE;
            end else begin
              m <= m >> 1;
            end
          end
          default: begin
            // IDLE and DONE hold everything until a start or reset.
          end
        endcase
      end
    end
  end

endmodule
